// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces the
// sensed row for press and release, and reports the hex key as row*4 + col.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                 DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]         DEB_LAST = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_reg, col_next;
    logic [1:0]       row_reg, row_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       code_reg, code_next;
    logic             valid_reg, valid_next;
    logic             held_reg, held_next;

    logic             tick;
    logic [3:0]       row_low;
    logic             any_low;
    logic [1:0]       sel_row;
    logic             cap_low;
    logic [3:0]       cnt_inc;

    assign tick    = (div_reg == DIV_LAST);
    assign row_low = ~row_in;
    assign any_low = |row_low;
    assign cap_low = row_low[row_reg];
    assign cnt_inc = cnt_reg + 4'd1;

    // Lowest-numbered low row wins when several keys share the strobed column.
    always_comb begin
        sel_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) sel_row = 2'(i);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SCAN;
            col_reg   <= 2'd0;
            row_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
            code_reg  <= 4'd0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            cnt_reg   <= cnt_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            held_reg  <= held_next;
        end
    end

    // All decisions happen on the last cycle of a column dwell.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        valid_next = 1'b0;
        held_next  = held_reg;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (any_low) begin
                        row_next = sel_row;
                        cnt_next = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            code_next  = {sel_row, col_reg};
                            valid_next = 1'b1;
                            held_next  = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (cap_low) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            code_next  = {row_reg, col_reg};
                            valid_next = 1'b1;
                            held_next  = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col_reg + 2'd1;
                    end
                end
                HELD: begin
                    if (!cap_low) begin
                        cnt_next = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            held_next  = 1'b0;
                            state_next = SCAN;
                            col_next   = col_reg + 2'd1;
                        end else begin
                            state_next = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!cap_low) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            held_next  = 1'b0;
                            state_next = SCAN;
                            col_next   = col_reg + 2'd1;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix driven by a sample-level
// model; every cycle the DUT outputs are compared against that model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: bit r*4+c set means the key at row r, column c is down.
    logic [15:0] pressed;

    // Reference model state, expressed as sample streaks rather than states.
    int   m_cyc, m_col, m_cap_row, m_press_streak, m_rel_streak, m_code;
    bit   m_locked, m_valid;
    int   cycle_no;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        compare_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s cycle=%0d got=%b expected=%b (col|code|valid|held)", tag, cycle_no, got, exp);
        end
    endtask

    function automatic logic [3:0] rows_for(input int col);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~pressed[i*4 + col];
        return r;
    endfunction

    task automatic model_update(input bit rst, input logic [3:0] rows);
        bit tk;
        if (rst) begin
            m_cyc = 0; m_col = 0; m_locked = 0; m_press_streak = 0;
            m_rel_streak = 0; m_code = 0; m_valid = 0; m_cap_row = 0;
            return;
        end
        tk = (m_cyc % SD) == SD - 1;
        m_cyc++;
        m_valid = 0;
        if (!tk) return;
        if (!m_locked) begin
            if (m_press_streak == 0) begin
                if (rows != 4'hF) begin
                    for (int i = 3; i >= 0; i--) if (!rows[i]) m_cap_row = i;
                    m_press_streak = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (!rows[m_cap_row]) begin
                m_press_streak++;
            end else begin
                m_press_streak = 0;
                m_col = (m_col + 1) % 4;
            end
            if (m_press_streak == DS) begin
                m_locked = 1; m_valid = 1;
                m_code = m_cap_row * 4 + m_col;
                m_press_streak = 0; m_rel_streak = 0;
            end
        end else begin
            if (rows[m_cap_row]) m_rel_streak++;
            else m_rel_streak = 0;
            if (m_rel_streak == DS) begin
                m_locked = 0; m_rel_streak = 0;
                m_col = (m_col + 1) % 4;
            end
        end
    endtask

    function automatic logic [9:0] expected();
        logic [3:0] c;
        c = ~(4'b0001 << m_col);
        return {c, 4'(m_code), m_valid, m_locked};
    endfunction

    // One clock: drive at negedge, let the edge happen, update model, compare.
    task automatic step(input bit rst, input logic [3:0] noise);
        logic [3:0] rows;
        @(negedge clk);
        reset  = rst;
        rows   = rows_for(m_col) ^ noise;
        row_in = rows;
        @(posedge clk);
        model_update(rst, rows);
        #1;
        check(rst ? "reset" : "outs", {col_out, key_code, key_valid, key_held}, expected());
        cycle_no = rst ? 0 : cycle_no + 1;
    endtask

    initial begin
        int dur, nk;
        logic [3:0] noise;
        reset = 1'b1; row_in = 4'hF; pressed = '0; cycle_no = 0;
        m_cyc = 0; m_col = 0; m_locked = 0; m_press_streak = 0;
        m_rel_streak = 0; m_code = 0; m_valid = 0; m_cap_row = 0;
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);

        // Directed: key 6 (row 1, col 2) held from cycle 0, released at cycle 30.
        pressed = 16'h0040;
        for (int k = 0; k < 48; k++) begin
            if (k == 30) pressed = '0;
            step(1'b0, 4'h0);
            if (k == 19) begin
                check("s1_valid", {9'd0, key_valid}, 10'd1);
                check("s1_code", {6'd0, key_code}, 10'd6);
                check("s1_col", {6'd0, col_out}, 10'b1011);
            end
            if (k == 39) begin
                check("s3_held", {9'd0, key_held}, 10'd0);
                check("s3_code", {6'd0, key_code}, 10'd6);
                check("s3_col", {6'd0, col_out}, 10'b0111);
            end
        end

        // Directed: two rows on column 0, then reset in the middle of debounce.
        step(1'b1, 4'h0);
        pressed = 16'h1010;
        for (int k = 0; k < 6; k++) step(1'b0, 4'h0);
        step(1'b1, 4'h0);
        check("s6_col", {6'd0, col_out}, 10'b1110);
        check("s6_held", {9'd0, key_held}, 10'd0);
        for (int k = 0; k < 20; k++) step(1'b0, 4'h0);
        check("s4_code", {6'd0, key_code}, 10'd4);
        check("s4_held", {9'd0, key_held}, 10'd1);
        step(1'b1, 4'h0);
        check("s6_code", {6'd0, key_code}, 10'd0);

        // Random key activity with contact noise and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            nk = $urandom_range(0, 9);
            pressed = '0;
            if (nk >= 5) pressed[$urandom_range(0, 15)] = 1'b1;
            if (nk == 9) pressed[$urandom_range(0, 15)] = 1'b1;
            dur = $urandom_range(1, 40);
            for (int k = 0; k < dur; k++) begin
                noise = ($urandom_range(0, 14) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
                step($urandom_range(0, 299) == 0, noise);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
